muldiv_unit: RTL

Parametrised iterative multiply/divide unit with integrated HI/LO registers for the EX stage of the pipelined MIPS core. It replaces the fixed unsigned multiplier and separate HiLo register. It adds signed multiply, signed and unsigned divide, MTHI/MTLO, a start/busy/done handshake for pipeline stalling, and abort for flushes. It computes one result bit per cycle using a shift-add multiply and a restoring divide.

---
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Produces one result bit per cycle: shift-add multiply, restoring divide.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t             stateQ, stateD;
    logic [CW-1:0]      countQ, countD;
    logic [2*WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0]   operandQ, operandD;
    logic [WIDTH-1:0]   origAQ, origAD;
    logic [WIDTH-1:0]   hiQ, hiD;
    logic [WIDTH-1:0]   loQ, loD;
    logic               isDivQ, isDivD;
    logic               negQ, negD;
    logic               negRemQ, negRemD;
    logic               divZeroQ, divZeroD;
    logic               doneQ, doneD;
    logic               dbzQ, dbzD;

    logic               accept;
    logic               isMulOp, isDivOp;
    logic               signA, signB;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShifted, divTrial;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quoFixed, remFixed;

    // Operand decode; op[0] selects the signed variant of MULT/DIV.
    always_comb begin
        accept  = start && !abort && (stateQ == IDLE);
        isMulOp = (op[2:1] == 2'b00);
        isDivOp = (op[2:1] == 2'b01);
        signA   = op[0] && dataA[WIDTH-1];
        signB   = op[0] && dataB[WIDTH-1];
        absA    = signA ? -dataA : dataA;
        absB    = signB ? -dataB : dataB;
    end

    // Iteration datapath: accQ holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mulSum     = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, operandQ} : {(WIDTH+1){1'b0}});
        divShifted = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
        divTrial   = divShifted - {1'b0, operandQ};
        prodFixed  = negQ ? -accQ : accQ;
        quoFixed   = negQ ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0];
        remFixed   = negRemQ ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= IDLE;
            countQ   <= '0;
            accQ     <= '0;
            operandQ <= '0;
            origAQ   <= '0;
            hiQ      <= '0;
            loQ      <= '0;
            isDivQ   <= 1'b0;
            negQ     <= 1'b0;
            negRemQ  <= 1'b0;
            divZeroQ <= 1'b0;
            doneQ    <= 1'b0;
            dbzQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            accQ     <= accD;
            operandQ <= operandD;
            origAQ   <= origAD;
            hiQ      <= hiD;
            loQ      <= loD;
            isDivQ   <= isDivD;
            negQ     <= negD;
            negRemQ  <= negRemD;
            divZeroQ <= divZeroD;
            doneQ    <= doneD;
            dbzQ     <= dbzD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (accept && isMulOp) begin
                    stateD = MUL;
                end else if (accept && isDivOp) begin
                    stateD = DIV;
                end
            end
            MUL, DIV: begin
                if (abort) begin
                    stateD = IDLE;
                end else if (countQ == CW'(WIDTH - 1)) begin
                    stateD = FIX;
                end
            end
            FIX: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_comb begin
        countD   = countQ;
        accD     = accQ;
        operandD = operandQ;
        origAD   = origAQ;
        hiD      = hiQ;
        loD      = loQ;
        isDivD   = isDivQ;
        negD     = negQ;
        negRemD  = negRemQ;
        divZeroD = divZeroQ;
        doneD    = 1'b0;
        dbzD     = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (accept && (isMulOp || isDivOp)) begin
                    accD     = isDivOp ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                    operandD = isDivOp ? absB : absA;
                    origAD   = dataA;
                    countD   = '0;
                    isDivD   = isDivOp;
                    negD     = signA ^ signB;
                    negRemD  = signA;
                    divZeroD = isDivOp && (dataB == '0);
                end else if (accept && (op == 3'b100)) begin
                    hiD = dataA;
                end else if (accept && (op == 3'b101)) begin
                    loD = dataA;
                end
            end
            MUL: begin
                if (!abort) begin
                    accD   = {mulSum, accQ[WIDTH-1:1]};
                    countD = countQ + CW'(1);
                end
            end
            DIV: begin
                if (!abort) begin
                    accD   = divTrial[WIDTH]
                           ? {divShifted[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0}
                           : {divTrial[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
                    countD = countQ + CW'(1);
                end
            end
            FIX: begin
                // A flush arriving on the commit cycle suppresses the write entirely.
                if (!abort) begin
                    doneD = 1'b1;
                    if (isDivQ && divZeroQ) begin
                        loD  = '1;
                        hiD  = origAQ;
                        dbzD = 1'b1;
                    end else if (isDivQ) begin
                        loD = quoFixed;
                        hiD = remFixed;
                    end else begin
                        hiD = prodFixed[2*WIDTH-1:WIDTH];
                        loD = prodFixed[WIDTH-1:0];
                    end
                end
            end
            default: begin
                doneD = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy        = (stateQ != IDLE);
        done        = doneQ;
        div_by_zero = dbzQ;
        hi_out      = hiQ;
        lo_out      = loQ;
    end

endmodule
